// File: rtl/bcd_xs3_codec.sv
// Sequential packed BCD <-> Excess-3 converter: one digit per cycle through a
// shared nibble converter, LSB digit first, with per-digit invalid flags.
module bcd_xs3_codec #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err,
  output logic [DIGITS-1:0]     out_err_mask
);

  localparam int unsigned     IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic                  mode_q;
  logic [4*DIGITS-1:0]   data_q;
  logic [4*DIGITS-1:0]   result_q;
  logic [DIGITS-1:0]     mask_q;
  logic [IDX_W-1:0]      idx_q;

  logic                  accept;
  logic                  last_digit;
  logic [3:0]            cur_digit;
  logic [3:0]            conv_nib;
  logic                  conv_err;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_digit = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)   state_d = CONV;
      CONV: if (last_digit) state_d = DONE;
      DONE: if (out_ready)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Outputs are gated to DONE so a partially built result is never visible.
  always_comb begin
    in_ready     = (state_q == IDLE);
    out_valid    = (state_q == DONE);
    out_data     = '0;
    out_err_mask = '0;
    out_err      = 1'b0;
    if (state_q == DONE) begin
      out_data     = result_q;
      out_err_mask = mask_q;
      out_err      = |mask_q;
    end
  end

  // Select the captured digit currently being converted
  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = data_q[4*i +: 4];
      end
    end
  end

  // Shared nibble converter; 4'hF marks an invalid digit in both directions
  always_comb begin
    conv_nib = 4'hF;
    conv_err = 1'b1;
    if (!mode_q) begin
      if (cur_digit <= 4'd9) begin
        conv_nib = cur_digit + 4'd3;
        conv_err = 1'b0;
      end
    end else begin
      if ((cur_digit >= 4'd3) && (cur_digit <= 4'd12)) begin
        conv_nib = cur_digit - 4'd3;
        conv_err = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
    end else if (accept) begin
      mode_q   <= in_mode;
      data_q   <= in_data;
      result_q <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
    end else if (state_q == CONV) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          result_q[4*i +: 4] <= conv_nib;
          mask_q[i]          <= conv_err;
        end
      end
      if (!last_digit) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_xs3_codec.sv
// Scoreboard bench for bcd_xs3_codec: driver pushes expected words, a negedge
// monitor checks latency and contents at each output handshake.
module tb_bcd_xs3_codec;

  localparam int unsigned DIGITS = 4;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic                in_mode;
  logic [4*DIGITS-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_data;
  logic                out_err;
  logic [DIGITS-1:0]   out_err_mask;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mask;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  bcd_xs3_codec #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err),
    .out_err_mask (out_err_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: latency on rising out_valid, contents on each handshake
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (sb.size() > 0) begin
        chk("latency", 32'(cyc), 32'(sb[0].acc + DIGITS));
      end else begin
        timeout_fail("unexpected_word");
      end
    end
    if (out_valid && out_ready && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("out_data", 32'(out_data), 32'(e.data));
      chk("out_err_mask", 32'(out_err_mask), 32'(e.mask));
      chk("out_err", 32'(out_err), 32'(|e.mask));
    end
    prev_valid = out_valid;
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic m,
                      input logic [15:0] ed, input logic [3:0] em);
    exp_t e;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout_fail("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    e.data = ed;
    e.mask = em;
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) timeout_fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] snap;
    logic        bp_ok;
    logic        quiet;
    int          n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_mask", 32'(out_err_mask), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(16'h0629, 1'b0, 16'h395C, 4'b0000);
    send(16'h395C, 1'b1, 16'h0629, 4'b0000);
    send(16'h1A3F, 1'b0, 16'h4F6F, 4'b0101);
    send(16'h0D33, 1'b1, 16'hFF00, 4'b1100);
    send(16'h8094, 1'b0, 16'hB3C7, 4'b0000);
    send(16'h3C2D, 1'b1, 16'h09FF, 4'b0011);
    send(16'hFFFF, 1'b0, 16'hFFFF, 4'b1111);
    send(16'h0000, 1'b1, 16'hFFFF, 4'b1111);
    drain();

    // Backpressure with noisy inputs while DONE holds
    out_ready = 1'b0;
    send(16'h5071, 1'b0, 16'h83A4, 4'b0000);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout_fail("bp_valid_timeout");
    snap  = out_data;
    bp_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      in_data  = 16'($urandom);
      in_mode  = ~in_mode;
      @(negedge clk);
      chk("bp_out_data", 32'(out_data), 32'(snap));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    chk("bp_snapshot", 32'(snap), 32'h83A4);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("recover_in_ready", 32'(in_ready), 32'd1);
    chk("recover_out_valid", 32'(out_valid), 32'd0);
    quiet = 1'b1;
    repeat (DIGITS + 3) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    chk("no_extra_word", 32'(quiet), 32'd1);
    chk("sb_empty_after_bp", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset on the second CONV cycle aborts the word
    send(16'h1234, 1'b0, 16'h4567, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    chk("abort_out_mask", 32'(out_err_mask), 32'd0);
    chk("abort_out_err", 32'(out_err), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(16'h9999, 1'b0, 16'hCCCC, 4'b0000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
